// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writebacks.
// Each source has a one-entry hold; a starvation-guarded priority arbiter drains them.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int ZERO_REG = 31
) (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [ADDR_W-1:0] l_rd,
  input  logic [DATA_W-1:0] l_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_L    = 2'd2
  } grant_e;

  logic              hold_a_v_q, hold_a_v_d;
  logic [ADDR_W-1:0] hold_a_rd_q, hold_a_rd_d;
  logic [DATA_W-1:0] hold_a_data_q, hold_a_data_d;
  logic              hold_l_v_q, hold_l_v_d;
  logic [ADDR_W-1:0] hold_l_rd_q, hold_l_rd_d;
  logic [DATA_W-1:0] hold_l_data_q, hold_l_data_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [31:0]       pending_q, pending_d;

  grant_e grant_s;
  logic   a_accept_s;
  logic   l_accept_s;

  function automatic logic [31:0] rd_mask(input logic v, input logic [ADDR_W-1:0] rd);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (v && (rd == ADDR_W'(i)) && (i != ZERO_REG)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Grant selection from hold state only, so ready never depends on valid.
  always_comb begin
    grant_s = GNT_NONE;
    if (hold_a_v_q && hold_l_v_q) begin
      if (wait_cnt_q >= WAIT_MAX) begin
        grant_s = GNT_A;
      end else begin
        grant_s = GNT_L;
      end
    end else if (hold_a_v_q) begin
      grant_s = GNT_A;
    end else if (hold_l_v_q) begin
      grant_s = GNT_L;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  assign a_ready    = !hold_a_v_q || (grant_s == GNT_A);
  assign l_ready    = !hold_l_v_q || (grant_s == GNT_L);
  assign a_accept_s = a_valid && a_ready;
  assign l_accept_s = l_valid && l_ready;

  // Next-state for holds, starvation counter and the write-port registers.
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    hold_a_v_d   = hold_a_v_q;
    hold_l_v_d   = hold_l_v_q;
    case (grant_s)
      GNT_A: begin
        hold_a_v_d   = 1'b0;
        regwrite_d   = (hold_a_rd_q != ZERO_IDX);
        write_reg_d  = hold_a_rd_q;
        write_data_d = hold_a_data_q;
      end
      GNT_L: begin
        hold_l_v_d   = 1'b0;
        regwrite_d   = (hold_l_rd_q != ZERO_IDX);
        write_reg_d  = hold_l_rd_q;
        write_data_d = hold_l_data_q;
      end
      GNT_NONE: begin
        regwrite_d = 1'b0;
      end
      default: begin
        regwrite_d = 1'b0;
      end
    endcase

    // A refill on the same edge as a drain keeps one write per cycle per source.
    hold_a_v_d    = a_accept_s ? 1'b1   : hold_a_v_d;
    hold_a_rd_d   = a_accept_s ? a_rd   : hold_a_rd_q;
    hold_a_data_d = a_accept_s ? a_data : hold_a_data_q;
    hold_l_v_d    = l_accept_s ? 1'b1   : hold_l_v_d;
    hold_l_rd_d   = l_accept_s ? l_rd   : hold_l_rd_q;
    hold_l_data_d = l_accept_s ? l_data : hold_l_data_q;

    if (!hold_a_v_q || (grant_s == GNT_A)) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if ((grant_s == GNT_L) && (wait_cnt_q < WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    pending_d = rd_mask(hold_a_v_d, hold_a_rd_d) | rd_mask(hold_l_v_d, hold_l_rd_d);
  end

  // State registers with synchronous reset; held writes are dropped on reset.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      hold_a_v_q    <= 1'b0;
      hold_a_rd_q   <= {ADDR_W{1'b0}};
      hold_a_data_q <= {DATA_W{1'b0}};
      hold_l_v_q    <= 1'b0;
      hold_l_rd_q   <= {ADDR_W{1'b0}};
      hold_l_data_q <= {DATA_W{1'b0}};
      wait_cnt_q    <= {WAIT_W{1'b0}};
      regwrite_q    <= 1'b0;
      write_reg_q   <= {ADDR_W{1'b0}};
      write_data_q  <= {DATA_W{1'b0}};
      pending_q     <= 32'd0;
    end else begin
      hold_a_v_q    <= hold_a_v_d;
      hold_a_rd_q   <= hold_a_rd_d;
      hold_a_data_q <= hold_a_data_d;
      hold_l_v_q    <= hold_l_v_d;
      hold_l_rd_q   <= hold_l_rd_d;
      hold_l_data_q <= hold_l_data_d;
      wait_cnt_q    <= wait_cnt_d;
      regwrite_q    <= regwrite_d;
      write_reg_q   <= write_reg_d;
      write_data_q  <= write_data_d;
      pending_q     <= pending_d;
    end
  end

  assign regWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention,
// XZR suppression, back-to-back stream and same-destination ordering.
module tb_regfile_wb_arbiter;

  logic        write_clk;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [63:0] a_data;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_rd;
  logic [63:0] l_data;
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic [31:0] pending;

  int checks_r;
  int errors_r;

  regfile_wb_arbiter #(
    .DATA_W(64), .ADDR_W(5), .MAX_WAIT(4), .ZERO_REG(31)
  ) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_rd      (l_rd),
    .l_data    (l_data),
    .regWrite  (regWrite),
    .write_reg (write_reg),
    .write_data(write_data),
    .pending   (pending)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_rw"}, 64'(regWrite), 64'd0);
    check({tag, "_pend"}, 64'(pending), 64'd0);
    check({tag, "_ar"}, 64'(a_ready), 64'd1);
    check({tag, "_lr"}, 64'(l_ready), 64'd1);
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [63:0] d);
    check({tag, "_rw"}, 64'(regWrite), 64'd1);
    check({tag, "_wr"}, 64'(write_reg), 64'(rd));
    check({tag, "_wd"}, write_data, d);
  endtask

  initial begin
    logic exp_a;
    checks_r = 0;
    errors_r = 0;
    reset   = 1'b1;
    a_valid = 1'b0; a_rd = 5'd0; a_data = 64'd0;
    l_valid = 1'b0; l_rd = 5'd0; l_data = 64'd0;
    tick();
    tick();
    expect_idle("rst0");
    check("rst0_wreg", 64'(write_reg), 64'd0);
    check("rst0_wdat", write_data, 64'd0);
    reset = 1'b0;

    // Single ALU write: pending while held, then one write cycle.
    a_valid = 1'b1; a_rd = 5'd9; a_data = 64'd256;
    tick();
    a_valid = 1'b0;
    check("alu_rw_early", 64'(regWrite), 64'd0);
    check("alu_pend", 64'(pending), 64'h200);
    tick();
    expect_write("alu", 5'd9, 64'd256);
    check("alu_pend_clr", 64'(pending), 64'd0);
    tick();
    check("alu_rw_off", 64'(regWrite), 64'd0);
    check("alu_wreg_hold", 64'(write_reg), 64'd9);

    // Contention: LLLLA repeating while both sources stay valid.
    a_valid = 1'b1; a_rd = 5'd10; a_data = 64'hA0;
    l_valid = 1'b1; l_rd = 5'd15; l_data = 64'hB0;
    tick();
    check("con_pend", 64'(pending), 64'h8400);
    check("con_rw0", 64'(regWrite), 64'd0);
    for (int k = 0; k < 10; k++) begin
      exp_a = ((k % 5) == 4);
      check($sformatf("con_ar%0d", k), 64'(a_ready), 64'(exp_a));
      check($sformatf("con_lr%0d", k), 64'(l_ready), 64'(!exp_a));
      tick();
      if (exp_a) expect_write($sformatf("con%0d", k), 5'd10, 64'hA0);
      else       expect_write($sformatf("con%0d", k), 5'd15, 64'hB0);
    end
    a_valid = 1'b0; l_valid = 1'b0;
    tick();
    expect_write("con_tail0", 5'd15, 64'hB0);
    tick();
    expect_write("con_tail1", 5'd10, 64'hA0);
    tick();
    expect_idle("con_end");

    // XZR: consumed, never issued, never pending.
    l_valid = 1'b1; l_rd = 5'd31; l_data = 64'hFFFF;
    check("xzr_lr", 64'(l_ready), 64'd1);
    tick();
    l_valid = 1'b0;
    check("xzr_rw0", 64'(regWrite), 64'd0);
    check("xzr_pend", 64'(pending), 64'd0);
    tick();
    check("xzr_rw1", 64'(regWrite), 64'd0);
    check("xzr_wreg", 64'(write_reg), 64'd31);
    tick();
    expect_idle("xzr_end");

    // Back-to-back load stream at one write per cycle.
    for (int i = 0; i < 8; i++) begin
      l_valid = 1'b1; l_rd = 5'(i); l_data = 64'd100 + 64'(i);
      check($sformatf("b2b_lr%0d", i), 64'(l_ready), 64'd1);
      tick();
      if (i == 0) check("b2b_rw_first", 64'(regWrite), 64'd0);
      else expect_write($sformatf("b2b%0d", i - 1), 5'(i - 1), 64'd100 + 64'(i - 1));
    end
    l_valid = 1'b0;
    tick();
    expect_write("b2b7", 5'd7, 64'd107);
    tick();
    expect_idle("b2b_end");

    // Same destination in both holds: load first, ALU value lands last.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'd1;
    l_valid = 1'b1; l_rd = 5'd5; l_data = 64'd2;
    tick();
    a_valid = 1'b0; l_valid = 1'b0;
    check("same_pend0", 64'(pending), 64'h20);
    tick();
    expect_write("same_first", 5'd5, 64'd2);
    check("same_pend1", 64'(pending), 64'h20);
    tick();
    expect_write("same_second", 5'd5, 64'd1);
    check("same_pend2", 64'(pending), 64'd0);
    tick();

    // Reset mid-traffic drops held writes.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    l_valid = 1'b1; l_rd = 5'd4; l_data = 64'h44;
    tick();
    check("mid_pend", 64'(pending), 64'h18);
    a_valid = 1'b0; l_valid = 1'b0;
    reset = 1'b1;
    tick();
    expect_idle("mid_rst0");
    tick();
    expect_idle("mid_rst1");
    check("mid_wreg", 64'(write_reg), 64'd0);
    reset = 1'b0;
    tick();
    expect_idle("mid_post0");
    tick();
    expect_idle("mid_post1");

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
